lcd_rx_win: RTL and testbench
=============================

// Module: lcd_rx_win
// PURPOSE
// - 8080-style parallel LCD write-bus receiver, successor of the fixed 16-bit receiver.
// - Synchronises the async bus and decodes command and parameter writes.
// - Tracks the CASET/PASET window, then emits each RAMWR/RAMWRC pixel tagged with x/y.
// - Supports 16-bit and 8-bit bus modes. Feeds the frame-buffer writer upstream of DVI.
// PARAMETERS
// BUS8        0    1: 8-bit bus, pixel = 2 bytes (MSB first); 0: 16-bit bus, 1 write/pixel
// DATA_W      16   i_lcd_data width; must be 8 when BUS8=1, 16 otherwise
// SYNC_STAGES 2    synchroniser depth on wr/rs/cs_n/rst_n/data, >=2
// X_W         9    coordinate width, x
// Y_W         9    coordinate width, y
// H_RES       320  reset window XE = H_RES-1
// V_RES       240  reset window YE = V_RES-1
// PORTS
// i_clk            in   1       system clock
// i_rst_n          in   1       async active-low reset
// i_lcd_wr         in   1       bus write strobe, data taken on rising edge
// i_lcd_rs         in   1       0=command, 1=data
// i_lcd_cs_n       in   1       chip select, active low
// i_lcd_rst_n      in   1       panel reset, active low (async, synchronised)
// i_lcd_data       in   DATA_W  bus data
// o_command        out  8       last command byte
// o_command_latch  out  1       1-cycle pulse, new o_command
// o_param          out  8       last non-pixel parameter byte
// o_param_latch    out  1       1-cycle pulse, new o_param
// o_pixel          out  16      RGB565 pixel
// o_pixel_x        out  X_W     x of o_pixel
// o_pixel_y        out  Y_W     y of o_pixel
// o_pixel_valid    out  1       1-cycle pulse, pixel/x/y valid
// o_frame_start    out  1       1-cycle pulse on RAMWR (0x2C) accept
// o_win_xs/xe      out  X_W     committed column window
// o_win_ys/ye      out  Y_W     committed row window
// BEHAVIOUR
// - Reset (i_rst_n low, or synced i_lcd_rst_n low):
//   - all pulses 0; o_command/o_param/o_pixel/x/y 0; window = (0,H_RES-1,0,V_RES-1).
//   - state IDLE. i_lcd_rst_n reset is synchronous after sync.
// - Sampling: write = synced wr rising edge with synced cs_n low; rs/data sampled aligned with wr.
//   - Outputs update SYNC_STAGES+2 cycles after pin wr rise.
// - rs=0 write:
//   - o_command <= data[7:0]; pulse command_latch; param index <= 0; byte phase <= 0.
//   - State: 0x2C -> PIX (cursor = xs,ys; pulse frame_start).
//   - 0x3C -> PIX, cursor kept. 0x2A -> CASET, 0x2B -> PASET, others -> PARAM.
// - rs=1 write in CASET/PASET/PARAM: o_param, param_latch pulse.
//   - Index counts 0..4, saturates at 4.
//   - CASET bytes: XS_H, XS_L, XE_H, XE_L (PASET same for Y). Values truncated to X_W/Y_W.
//   - Commit on 4th byte only if start<=end; else previous window held.
// - rs=1 write in PIX:
//   - BUS8=0: each write = one pixel.
//   - BUS8=1: phase 0 stores high byte, phase 1 completes pixel.
//   - Emit o_pixel at cursor, valid pulse. No param_latch in PIX.
// - Cursor advance after each pixel:
//   - x==xe -> x=xs, y+1.
//   - x==xe && y==ye -> (xs,ys), wrap, no error.
// - Window commit while in PIX does not move cursor until next 0x2C.
// - cs_n rising: byte phase cleared, state kept. Partial byte discarded.
// - Command and data writes are mutually exclusive by construction; no simultaneous pulses.
// STRUCTURE
// - Package lcd_rx_pkg: CMD_CASET 8'h2A, CMD_PASET 8'h2B, CMD_RAMWR 8'h2C, CMD_RAMWRC 8'h3C;
//   state enum IDLE/PARAM/CASET/PASET/PIX.
// - Sub-module lcd_bus_sync: SYNC_STAGES synchroniser, wr-edge detect; outputs wr_stb, rs, data.
// - Top: decode FSM, window regs, cursor counters, byte assembler.
// TESTING
// - Reset, no writes -> all pulses 0, window (0,319,0,239).
// - CASET 00,0A,00,0C; PASET 00,05,00,06; 0x2C; 6 pixels 0x1111..0x6666
//   -> (10,5)(11,5)(12,5)(10,6)(11,6)(12,6); 7th pixel at (10,5).
// - CASET 00,20,00,10 (XS>XE) -> o_param pulses x4, window unchanged.
// - BUS8=1: 0x2C, bytes F8,00,07,E0 -> pixels 0xF800 then 0x07E0, 2 valid pulses.
// - 0x2C, 2 pixels, 0x00, 0x3C, 1 pixel -> third pixel continues at cursor 2.
// - i_lcd_rst_n low mid-PIX -> outputs and window to reset values; next data write gives param_latch, not pixel.

Source files
------------

// File: rtl/lcd_rx_pkg.sv
// lcd_rx_pkg: command codes and decoder states shared by the LCD write-bus receiver.
package lcd_rx_pkg;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_PASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC = 8'h3C;
    typedef enum logic [2:0] {IDLE, PARAM, CASET, PASET, PIX} state_e;
endpackage

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: brings the asynchronous 8080 bus into i_clk and flags each selected wr rising edge.
module lcd_bus_sync #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              lcd_wr_i,
    input  logic              lcd_rs_i,
    input  logic              lcd_cs_n_i,
    input  logic              lcd_rst_n_i,
    input  logic [DATA_W-1:0] lcd_data_i,
    output logic              wr_stb_o,
    output logic              rs_o,
    output logic              cs_rise_o,
    output logic              lcd_rst_n_o,
    output logic [DATA_W-1:0] data_o
);
    localparam int W = DATA_W + 4;
    // Idle bus: wr low, deselected, panel held in reset until the chain fills.
    localparam logic [W-1:0] SYNC_RST = {4'b0010, {DATA_W{1'b0}}};
    logic [W-1:0]      sync_q [SYNC_STAGES];
    logic [W-1:0]      s;
    logic              wr_prev_q, cs_prev_q, wr_stb_q, rs_q, cs_rise_q, lcd_rst_n_q;
    logic [DATA_W-1:0] data_q;
    assign s = sync_q[SYNC_STAGES-1];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            wr_prev_q   <= 1'b0;
            cs_prev_q   <= 1'b1;
            wr_stb_q    <= 1'b0;
            rs_q        <= 1'b0;
            cs_rise_q   <= 1'b0;
            lcd_rst_n_q <= 1'b0;
            data_q      <= '0;
        end else begin
            sync_q[0] <= {lcd_wr_i, lcd_rs_i, lcd_cs_n_i, lcd_rst_n_i, lcd_data_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            wr_prev_q   <= s[W-1];
            cs_prev_q   <= s[W-3];
            wr_stb_q    <= s[W-1] & ~wr_prev_q & ~s[W-3];
            rs_q        <= s[W-2];
            cs_rise_q   <= s[W-3] & ~cs_prev_q;
            lcd_rst_n_q <= s[W-4];
            data_q      <= s[DATA_W-1:0];
        end
    end
    assign wr_stb_o    = wr_stb_q;
    assign rs_o        = rs_q;
    assign cs_rise_o   = cs_rise_q;
    assign lcd_rst_n_o = lcd_rst_n_q;
    assign data_o      = data_q;
endmodule

// File: rtl/lcd_rx_win.sv
// lcd_rx_win: 8080 LCD write-bus receiver; decodes commands/params, tracks the
// CASET/PASET window and emits RAMWR/RAMWRC pixels tagged with their x/y.
module lcd_rx_win #(
    parameter int BUS8        = 0,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int X_W         = 9,
    parameter int Y_W         = 9,
    parameter int H_RES       = 320,
    parameter int V_RES       = 240
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lcd_wr,
    input  logic              i_lcd_rs,
    input  logic              i_lcd_cs_n,
    input  logic              i_lcd_rst_n,
    input  logic [DATA_W-1:0] i_lcd_data,
    output logic [7:0]        o_command,
    output logic              o_command_latch,
    output logic [7:0]        o_param,
    output logic              o_param_latch,
    output logic [15:0]       o_pixel,
    output logic [X_W-1:0]    o_pixel_x,
    output logic [Y_W-1:0]    o_pixel_y,
    output logic              o_pixel_valid,
    output logic              o_frame_start,
    output logic [X_W-1:0]    o_win_xs,
    output logic [X_W-1:0]    o_win_xe,
    output logic [Y_W-1:0]    o_win_ys,
    output logic [Y_W-1:0]    o_win_ye
);
    import lcd_rx_pkg::*;
    typedef struct packed {
        state_e         state;
        logic [7:0]     cmd;
        logic           cmd_latch;
        logic [7:0]     param;
        logic           param_latch;
        logic [15:0]    pixel;
        logic [X_W-1:0] px;
        logic [Y_W-1:0] py;
        logic           pix_valid;
        logic           frame;
        logic [X_W-1:0] xs, xe, cx;
        logic [Y_W-1:0] ys, ye, cy;
        logic [2:0]     idx;
        logic           phase;
        logic [7:0]     hi, b0, b1, b2;
    } regs_t;
    localparam regs_t RST = '{state: IDLE, cmd: '0, cmd_latch: 1'b0, param: '0, param_latch: 1'b0,
                              pixel: '0, px: '0, py: '0, pix_valid: 1'b0, frame: 1'b0,
                              xs: '0, xe: X_W'(H_RES - 1), cx: '0, ys: '0, ye: Y_W'(V_RES - 1), cy: '0,
                              idx: '0, phase: 1'b0, hi: '0, b0: '0, b1: '0, b2: '0};
    logic              wr_stb, rs, cs_rise, lcd_rst_n, last_x;
    logic [DATA_W-1:0] data;
    logic [7:0]        data_b;
    logic [15:0]       data_w;
    logic [X_W-1:0]    sx, ex;
    logic [Y_W-1:0]    sy, ey;
    regs_t             r_q, r_d;
    lcd_bus_sync #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .lcd_wr_i(i_lcd_wr), .lcd_rs_i(i_lcd_rs),
        .lcd_cs_n_i(i_lcd_cs_n), .lcd_rst_n_i(i_lcd_rst_n), .lcd_data_i(i_lcd_data),
        .wr_stb_o(wr_stb), .rs_o(rs), .cs_rise_o(cs_rise), .lcd_rst_n_o(lcd_rst_n), .data_o(data)
    );
    assign data_b = data[7:0];
    assign data_w = 16'(data);
    // Window bounds arrive big-endian; the 4th byte is still on the bus when the commit happens.
    assign sx     = X_W'({r_q.b0, r_q.b1});
    assign ex     = X_W'({r_q.b2, data_b});
    assign sy     = Y_W'({r_q.b0, r_q.b1});
    assign ey     = Y_W'({r_q.b2, data_b});
    assign last_x = r_q.cx == r_q.xe;
    always_comb begin
        r_d             = r_q;
        r_d.cmd_latch   = 1'b0;
        r_d.param_latch = 1'b0;
        r_d.pix_valid   = 1'b0;
        r_d.frame       = 1'b0;
        if (cs_rise) r_d.phase = 1'b0;
        if (wr_stb && !rs) begin
            r_d.cmd       = data_b;
            r_d.cmd_latch = 1'b1;
            r_d.idx       = 3'd0;
            r_d.phase     = 1'b0;
            r_d.state     = (data_b == CMD_RAMWR || data_b == CMD_RAMWRC) ? PIX :
                            data_b == CMD_CASET ? CASET : data_b == CMD_PASET ? PASET : PARAM;
            if (data_b == CMD_RAMWR) begin
                r_d.cx    = r_q.xs;
                r_d.cy    = r_q.ys;
                r_d.frame = 1'b1;
            end
        end else if (wr_stb && r_q.state == PIX) begin
            if (BUS8 != 0 && !r_q.phase) begin
                r_d.hi    = data_b;
                r_d.phase = 1'b1;
            end else begin
                r_d.pixel     = BUS8 != 0 ? {r_q.hi, data_b} : data_w;
                r_d.px        = r_q.cx;
                r_d.py        = r_q.cy;
                r_d.pix_valid = 1'b1;
                r_d.phase     = 1'b0;
                r_d.cx        = last_x ? r_q.xs : r_q.cx + X_W'(1);
                r_d.cy        = !last_x ? r_q.cy : r_q.cy == r_q.ye ? r_q.ys : r_q.cy + Y_W'(1);
            end
        end else if (wr_stb) begin
            r_d.param       = data_b;
            r_d.param_latch = 1'b1;
            r_d.idx         = r_q.idx == 3'd4 ? 3'd4 : r_q.idx + 3'd1;
            r_d.b0          = r_q.idx == 3'd0 ? data_b : r_q.b0;
            r_d.b1          = r_q.idx == 3'd1 ? data_b : r_q.b1;
            r_d.b2          = r_q.idx == 3'd2 ? data_b : r_q.b2;
            if (r_q.idx == 3'd3 && r_q.state == CASET && sx <= ex) begin
                r_d.xs = sx;
                r_d.xe = ex;
            end
            if (r_q.idx == 3'd3 && r_q.state == PASET && sy <= ey) begin
                r_d.ys = sy;
                r_d.ye = ey;
            end
        end
        if (!lcd_rst_n) r_d = RST;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= RST;
        else r_q <= r_d;
    end
    assign o_command       = r_q.cmd;
    assign o_command_latch = r_q.cmd_latch;
    assign o_param         = r_q.param;
    assign o_param_latch   = r_q.param_latch;
    assign o_pixel         = r_q.pixel;
    assign o_pixel_x       = r_q.px;
    assign o_pixel_y       = r_q.py;
    assign o_pixel_valid   = r_q.pix_valid;
    assign o_frame_start   = r_q.frame;
    assign o_win_xs        = r_q.xs;
    assign o_win_xe        = r_q.xe;
    assign o_win_ys        = r_q.ys;
    assign o_win_ye        = r_q.ye;
endmodule

// File: tb/tb_lcd_rx_win.sv
// tb_lcd_rx_win: scoreboard bench for a 16-bit and an 8-bit receiver instance.
module tb_lcd_rx_win;
    typedef struct packed {
        logic [2:0]  p;
        logic [15:0] v;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        f;
    } ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0, lrst_n = 1'b1, cs_n = 1'b0;
    logic wr16 = 1'b0, rs16 = 1'b0, wr8 = 1'b0, rs8 = 1'b0;
    logic [15:0] d16 = '0;
    logic [7:0]  d8 = '0;
    logic [7:0]  cmd16, par16, cmd8, par8;
    logic        cl16, pl16, pv16, fs16, cl8, pl8, pv8, fs8;
    logic [15:0] pix16, pix8;
    logic [8:0]  px16, py16, xs16, xe16, ys16, ye16, px8, py8, xs8, xe8, ys8, ye8;
    ev_t q16[$], q8[$];
    ev_t a16, e16, a8, e8;
    int checks = 0, passed = 0;
    always #5 clk = ~clk;
    lcd_rx_win #(.BUS8(0), .DATA_W(16)) u16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_lcd_wr(wr16), .i_lcd_rs(rs16), .i_lcd_cs_n(cs_n),
        .i_lcd_rst_n(lrst_n), .i_lcd_data(d16), .o_command(cmd16), .o_command_latch(cl16),
        .o_param(par16), .o_param_latch(pl16), .o_pixel(pix16), .o_pixel_x(px16), .o_pixel_y(py16),
        .o_pixel_valid(pv16), .o_frame_start(fs16), .o_win_xs(xs16), .o_win_xe(xe16),
        .o_win_ys(ys16), .o_win_ye(ye16)
    );
    lcd_rx_win #(.BUS8(1), .DATA_W(8)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_lcd_wr(wr8), .i_lcd_rs(rs8), .i_lcd_cs_n(cs_n),
        .i_lcd_rst_n(lrst_n), .i_lcd_data(d8), .o_command(cmd8), .o_command_latch(cl8),
        .o_param(par8), .o_param_latch(pl8), .o_pixel(pix8), .o_pixel_x(px8), .o_pixel_y(py8),
        .o_pixel_valid(pv8), .o_frame_start(fs8), .o_win_xs(xs8), .o_win_xe(xe8),
        .o_win_ys(ys8), .o_win_ye(ye8)
    );
    function automatic ev_t mk(input logic [2:0] p, input logic [15:0] v, input logic [8:0] x,
                               input logic [8:0] y, input logic f);
        return {p, v, x, y, f};
    endfunction
    always @(negedge clk) begin
        if (cl16 | pl16 | pv16 | fs16) begin
            a16 = mk({cl16, pl16, pv16}, pv16 ? pix16 : cl16 ? {8'h0, cmd16} : {8'h0, par16},
                     pv16 ? px16 : 9'd0, pv16 ? py16 : 9'd0, fs16);
            checks++;
            if (q16.size() == 0) $display("FAIL mon16 unexpected event got %h want none", a16);
            else begin
                e16 = q16.pop_front();
                if (a16 !== e16) $display("FAIL mon16 event got %h want %h", a16, e16);
                else passed++;
            end
        end
    end
    always @(negedge clk) begin
        if (cl8 | pl8 | pv8 | fs8) begin
            a8 = mk({cl8, pl8, pv8}, pv8 ? pix8 : cl8 ? {8'h0, cmd8} : {8'h0, par8},
                    pv8 ? px8 : 9'd0, pv8 ? py8 : 9'd0, fs8);
            checks++;
            if (q8.size() == 0) $display("FAIL mon8 unexpected event got %h want none", a8);
            else begin
                e8 = q8.pop_front();
                if (a8 !== e8) $display("FAIL mon8 event got %h want %h", a8, e8);
                else passed++;
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s got %0d want %0d", name, act, exp);
        else passed++;
    endtask
    task automatic win16(input int xs, input int xe, input int ys, input int ye);
        chk("win16_xs", 32'(xs16), xs); chk("win16_xe", 32'(xe16), xe);
        chk("win16_ys", 32'(ys16), ys); chk("win16_ye", 32'(ye16), ye);
    endtask
    task automatic bus16(input logic rs, input logic [15:0] d);
        @(negedge clk); rs16 = rs; d16 = d;
        repeat (3) @(negedge clk); wr16 = 1'b1;
        repeat (3) @(negedge clk); wr16 = 1'b0;
        repeat (3) @(negedge clk);
    endtask
    task automatic bus8(input logic rs, input logic [7:0] d);
        @(negedge clk); rs8 = rs; d8 = d;
        repeat (3) @(negedge clk); wr8 = 1'b1;
        repeat (3) @(negedge clk); wr8 = 1'b0;
        repeat (3) @(negedge clk);
    endtask
    task automatic cmd_16(input logic [7:0] c);
        q16.push_back(mk(3'b100, {8'h0, c}, 9'd0, 9'd0, c == 8'h2C));
        bus16(1'b0, {8'h0, c});
    endtask
    task automatic par_16(input logic [7:0] b);
        q16.push_back(mk(3'b010, {8'h0, b}, 9'd0, 9'd0, 1'b0));
        bus16(1'b1, {8'h0, b});
    endtask
    task automatic pix_16(input logic [15:0] v, input int x, input int y);
        q16.push_back(mk(3'b001, v, 9'(x), 9'(y), 1'b0));
        bus16(1'b1, v);
    endtask
    task automatic cmd_8(input logic [7:0] c);
        q8.push_back(mk(3'b100, {8'h0, c}, 9'd0, 9'd0, c == 8'h2C));
        bus8(1'b0, c);
    endtask
    task automatic pix_8(input logic [15:0] v, input int x, input int y);
        bus8(1'b1, v[15:8]);
        q8.push_back(mk(3'b001, v, 9'(x), 9'(y), 1'b0));
        bus8(1'b1, v[7:0]);
    endtask
    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        win16(0, 319, 0, 239);
        chk("rst_cmd16", 32'(cmd16), 0);
        chk("rst_pix16", 32'(pix16), 0);
        chk("rst_pulses16", {28'd0, cl16, pl16, pv16, fs16}, 0);
        chk("rst_xe8", 32'(xe8), 319);
        chk("rst_ye8", 32'(ye8), 239);
        // Window 10..12 x 5..6, then seven pixels wrap back to the origin.
        cmd_16(8'h2A); par_16(8'h00); par_16(8'h0A); par_16(8'h00); par_16(8'h0C);
        cmd_16(8'h2B); par_16(8'h00); par_16(8'h05); par_16(8'h00); par_16(8'h06);
        win16(10, 12, 5, 6);
        cmd_16(8'h2C);
        pix_16(16'h1111, 10, 5); pix_16(16'h2222, 11, 5); pix_16(16'h3333, 12, 5);
        pix_16(16'h4444, 10, 6); pix_16(16'h5555, 11, 6); pix_16(16'h6666, 12, 6);
        pix_16(16'h7777, 10, 5);
        cmd_16(8'h2A); par_16(8'h00); par_16(8'h20); par_16(8'h00); par_16(8'h10);
        win16(10, 12, 5, 6);
        cmd_16(8'h2C);
        pix_16(16'hA001, 10, 5); pix_16(16'hA002, 11, 5);
        cmd_16(8'h00); cmd_16(8'h3C);
        pix_16(16'hA003, 12, 5); pix_16(16'hA004, 10, 6);
        @(negedge clk); cs_n = 1'b1;
        repeat (4) @(negedge clk);
        bus16(1'b1, 16'hDEAD);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        // 8-bit bus: two bytes per pixel, a deselect drops the pending high byte.
        cmd_8(8'h2C);
        pix_8(16'hF800, 0, 0); pix_8(16'h07E0, 1, 0);
        bus8(1'b1, 8'h12);
        @(negedge clk); cs_n = 1'b1;
        repeat (6) @(negedge clk); cs_n = 1'b0;
        repeat (6) @(negedge clk);
        pix_8(16'h3456, 2, 0);
        cmd_16(8'h2C);
        pix_16(16'hB001, 10, 5);
        @(negedge clk); lrst_n = 1'b0;
        repeat (8) @(negedge clk); lrst_n = 1'b1;
        repeat (8) @(negedge clk);
        win16(0, 319, 0, 239);
        chk("prst_cmd16", 32'(cmd16), 0);
        chk("prst_pix16", 32'(pix16), 0);
        chk("prst_px16", 32'(px16), 0);
        chk("prst_xs8", 32'(xs8), 0);
        chk("prst_xe8", 32'(xe8), 319);
        par_16(8'h55);
        q8.push_back(mk(3'b010, 16'h0077, 9'd0, 9'd0, 1'b0));
        bus8(1'b1, 8'h77);
        repeat (20) @(negedge clk);
        chk("q16_drained", q16.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
